// File: rtl/exec_pkg.sv
// Shared decode types for the issue stage and the ALU: instruction layout and issue FSM states.
package exec_pkg;

  localparam int INSTR_W = 16;
  localparam int FT_W    = 2;
  localparam int FC_W    = 2;
  localparam int RF_AW   = 4;

  typedef struct packed {
    logic [FT_W-1:0]  funtype;
    logic [FC_W-1:0]  funcode;
    logic [RF_AW-1:0] rd;
    logic [RF_AW-1:0] rs1;
    logic [RF_AW-1:0] rs2;
  } instr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } issue_state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register busy vector: set on issue of rd, cleared on writeback (set wins on collision).
module issue_scoreboard #(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] lk_a,
  input  logic [REG_AW-1:0] lk_b,
  input  logic [REG_AW-1:0] lk_c,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_c
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0] busy_p1;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_p1;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_p1 <= '0;
    else        busy_p1 <= busy_nxt;
  end

  assign busy_a = busy_p1[lk_a];
  assign busy_b = busy_p1[lk_b];
  assign busy_c = busy_p1[lk_c];

endmodule

// File: rtl/exec_issue_stage.sv
// Decode/issue stage: reads rs1/rs2/rd, blocks on scoreboard hazards, hands one op per cycle to the ALU.
// Optional ISSUE_FWD_EN: writeback data bypasses the regfile and the scoreboard in the writeback cycle.
module exec_issue_stage
  import exec_pkg::*;
#(
  parameter int DATA_W  = 6,
  parameter int REG_AW  = 4,
  parameter int CACHE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [CACHE_W-1:0] in_cache,
  output logic [REG_AW-1:0]  rs1_addr,
  output logic [REG_AW-1:0]  rs2_addr,
  output logic [REG_AW-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rs1_data,
  input  logic [DATA_W-1:0]  rs2_data,
  input  logic [DATA_W-1:0]  rd_data,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  opa,
  output logic [DATA_W-1:0]  opb,
  output logic [DATA_W-1:0]  kernel_reg,
  output logic [CACHE_W-1:0] cache,
  output logic [FT_W-1:0]    funtype,
  output logic [FC_W-1:0]    funcode,
  output logic [REG_AW-1:0]  out_rd
);

  instr_t ins_p0;
  assign ins_p0   = instr_t'(in_instr);
  assign rs1_addr = ins_p0.rs1;
  assign rs2_addr = ins_p0.rs2;
  assign rd_addr  = ins_p0.rd;

  logic busy_rs1, busy_rs2, busy_rd;
  logic fwd_rs1, fwd_rs2, fwd_rd;
  logic [DATA_W-1:0] a_p0, b_p0, k_p0;

`ifdef ISSUE_FWD_EN
  assign fwd_rs1 = wb_valid && (wb_addr == ins_p0.rs1);
  assign fwd_rs2 = wb_valid && (wb_addr == ins_p0.rs2);
  assign fwd_rd  = wb_valid && (wb_addr == ins_p0.rd);
  assign a_p0    = fwd_rs1 ? wb_data : rs1_data;
  assign b_p0    = fwd_rs2 ? wb_data : rs2_data;
  assign k_p0    = fwd_rd  ? wb_data : rd_data;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
  assign fwd_rd  = 1'b0;
  assign a_p0    = rs1_data;
  assign b_p0    = rs2_data;
  assign k_p0    = rd_data;
`endif

  logic hazard, accept, vld_p1;
  issue_state_e state, state_nxt;

  assign hazard   = (busy_rs1 & ~fwd_rs1) | (busy_rs2 & ~fwd_rs2) | (busy_rd & ~fwd_rd);
  assign vld_p1   = (state == HOLD);
  assign in_ready = ~hazard & (~vld_p1 | out_ready);
  assign accept   = in_valid & in_ready;

  issue_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept),
    .set_addr (ins_p0.rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .lk_a     (ins_p0.rs1),
    .lk_b     (ins_p0.rs2),
    .lk_c     (ins_p0.rd),
    .busy_a   (busy_rs1),
    .busy_b   (busy_rs2),
    .busy_c   (busy_rd)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (accept)                  state_nxt = HOLD;
        else if (in_valid && hazard) state_nxt = STALL;
      end
      HOLD: begin
        if (accept)                               state_nxt = HOLD;
        else if (out_ready && in_valid && hazard) state_nxt = STALL;
        else if (out_ready)                       state_nxt = EMPTY;
      end
      STALL: begin
        if (accept)         state_nxt = HOLD;
        else if (!in_valid) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Stage p0 -> p1: operand/control registers feeding the ALU
  logic [DATA_W-1:0]  opa_p1, opb_p1, kreg_p1;
  logic [CACHE_W-1:0] cache_p1;
  logic [FT_W-1:0]    ft_p1;
  logic [FC_W-1:0]    fc_p1;
  logic [REG_AW-1:0]  rd_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_p1   <= '0;
      opb_p1   <= '0;
      kreg_p1  <= '0;
      cache_p1 <= '0;
      ft_p1    <= '0;
      fc_p1    <= '0;
      rd_p1    <= '0;
    end else if (accept) begin
      opa_p1   <= a_p0;
      opb_p1   <= b_p0;
      kreg_p1  <= k_p0;
      cache_p1 <= in_cache;
      ft_p1    <= ins_p0.funtype;
      fc_p1    <= ins_p0.funcode;
      rd_p1    <= ins_p0.rd;
    end
  end

  assign out_valid  = vld_p1;
  assign opa        = opa_p1;
  assign opb        = opb_p1;
  assign kernel_reg = kreg_p1;
  assign cache      = cache_p1;
  assign funtype    = ft_p1;
  assign funcode    = fc_p1;
  assign out_rd     = rd_p1;

endmodule

// File: tb/tb_exec_issue_stage.sv
// Directed bench for exec_issue_stage: table-driven independent stream plus hazard/hold/reset sequences.
module tb_exec_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_instr, in_cache;
  logic [3:0]  rs1_addr, rs2_addr, rd_addr;
  logic [5:0]  rs1_data, rs2_data, rd_data;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [5:0]  wb_data;
  logic        out_valid, out_ready;
  logic [5:0]  opa, opb, kernel_reg;
  logic [15:0] cache;
  logic [1:0]  funtype, funcode;
  logic [3:0]  out_rd;

  logic [5:0] regs [16];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign rd_data  = regs[rd_addr];

  always #5 clk = ~clk;

  exec_issue_stage #(.DATA_W(6), .REG_AW(4), .CACHE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_cache(in_cache),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opa(opa), .opb(opb), .kernel_reg(kernel_reg), .cache(cache),
    .funtype(funtype), .funcode(funcode), .out_rd(out_rd)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [15:0] cch;
    logic [5:0]  a, b, k;
    logic [1:0]  ft, fc;
    logic [3:0]  rd;
  } vec_t;

  vec_t vt [8];

  initial begin
    // regs[i] = i+20 except r2=9, r3=12
    for (int i = 0; i < 16; i++) regs[i] = 6'(i + 20);
    regs[2] = 6'd9;
    regs[3] = 6'd12;

    vt[0] = '{16'h1823, 16'hC000, 6'd9,  6'd12, 6'd28, 2'd0, 2'd1, 4'd8};
    vt[1] = '{16'h4901, 16'hC001, 6'd20, 6'd21, 6'd29, 2'd1, 2'd0, 4'd9};
    vt[2] = '{16'hBA45, 16'hC002, 6'd24, 6'd25, 6'd30, 2'd2, 2'd3, 4'd10};
    vt[3] = '{16'hEB67, 16'hC003, 6'd26, 6'd27, 6'd31, 2'd3, 2'd2, 4'd11};
    vt[4] = '{16'h0C76, 16'hC004, 6'd27, 6'd26, 6'd32, 2'd0, 2'd0, 4'd12};
    vt[5] = '{16'h5D32, 16'hC005, 6'd12, 6'd9,  6'd33, 2'd1, 2'd1, 4'd13};
    vt[6] = '{16'hAE11, 16'hC006, 6'd21, 6'd21, 6'd34, 2'd2, 2'd2, 4'd14};
    vt[7] = '{16'hFF04, 16'hC007, 6'd20, 6'd24, 6'd35, 2'd3, 2'd3, 4'd15};

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_cache = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_opa", opa, 0);
    chk("rst_cache", cache, 0);
    chk("rst_in_ready", in_ready, 1);

    // Test 1: add r1 <- r2, r3
    @(negedge clk);
    in_valid = 1'b1; in_instr = 16'h1123; in_cache = 16'hABCD;
    #1 chk("t1_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_opa", opa, 9);
    chk("t1_opb", opb, 12);
    chk("t1_kreg", kernel_reg, 21);
    chk("t1_funtype", funtype, 0);
    chk("t1_funcode", funcode, 1);
    chk("t1_out_rd", out_rd, 1);
    chk("t1_cache", cache, 16'hABCD);

    // Test 2: RAW on r1
    @(negedge clk);
    in_instr = 16'h1214; in_cache = 16'h0202;
    #1 chk("t2_stall_ready", in_ready, 0);
    @(posedge clk); #1 chk("t2_stall_valid", out_valid, 0);
    @(negedge clk); #1 chk("t2_stall_ready2", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 4'd1; wb_data = 6'd50;
`ifdef ISSUE_FWD_EN
    #1 chk("t2_wb_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("t2_issue_valid", out_valid, 1);
    chk("t2_issue_opa", opa, 50);
    @(negedge clk);
    wb_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
`else
    #1 chk("t2_wb_ready", in_ready, 0);
    @(posedge clk); #1 chk("t2_wb_valid", out_valid, 0);
    @(negedge clk);
    wb_valid = 1'b0;
    #1 chk("t2_after_wb_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("t2_issue_valid", out_valid, 1);
    chk("t2_issue_opa", opa, 21);
`endif
    chk("t2_issue_opb", opb, 24);
    chk("t2_issue_kreg", kernel_reg, 9);
    chk("t2_issue_rd", out_rd, 2);

    // Test 3: downstream backpressure for 3 cycles, new independent instr waiting
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h3567; in_cache = 16'h0303;
      #1 chk("t3_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("t3_out_valid", out_valid, 1);
`ifdef ISSUE_FWD_EN
      chk("t3_opa", opa, 50);
`else
      chk("t3_opa", opa, 21);
`endif
      chk("t3_opb", opb, 24);
      chk("t3_funcode", funcode, 1);
      chk("t3_out_rd", out_rd, 2);
    end

    // Test 4: issue rd=5 on the same edge as writeback of r5
    @(negedge clk);
    out_ready = 1'b1; wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 6'd7;
    #1 chk("t4_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("t4_out_valid", out_valid, 1);
    chk("t4_opa", opa, 26);
    chk("t4_opb", opb, 27);
`ifdef ISSUE_FWD_EN
    chk("t4_kreg", kernel_reg, 7);
`else
    chk("t4_kreg", kernel_reg, 25);
`endif
    chk("t4_funcode", funcode, 3);
    chk("t4_out_rd", out_rd, 5);
    @(negedge clk);
    wb_valid = 1'b0; in_instr = 16'h1650;
    #1 chk("t4_r5_busy_ready", in_ready, 0);
    @(posedge clk); #1 chk("t4_stall_valid", out_valid, 0);

    // Test 5: reset while holding an op under backpressure
    @(negedge clk);
    in_instr = 16'h0789; in_cache = 16'h0505;
    #1 chk("t5_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("t5_out_valid", out_valid, 1);
    chk("t5_opa", opa, 28);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 chk("t5_hold_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_opa", opa, 0);
    chk("t5_rst_rd", out_rd, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h1652;
    #1 chk("t5_sb_clear_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("t5_post_valid", out_valid, 1);
    chk("t5_post_opa", opa, 25);
    chk("t5_post_opb", opb, 9);
    chk("t5_post_kreg", kernel_reg, 26);

    // Test 6: independent stream, one issue per cycle
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vt[i].instr; in_cache = vt[i].cch;
      #1 chk($sformatf("t6_in_ready[%0d]", i), in_ready, 1);
      @(posedge clk); #1;
      chk($sformatf("t6_valid[%0d]", i), out_valid, 1);
      chk($sformatf("t6_opa[%0d]", i), opa, vt[i].a);
      chk($sformatf("t6_opb[%0d]", i), opb, vt[i].b);
      chk($sformatf("t6_kreg[%0d]", i), kernel_reg, vt[i].k);
      chk($sformatf("t6_ft[%0d]", i), funtype, vt[i].ft);
      chk($sformatf("t6_fc[%0d]", i), funcode, vt[i].fc);
      chk($sformatf("t6_rd[%0d]", i), out_rd, vt[i].rd);
      chk($sformatf("t6_cache[%0d]", i), cache, vt[i].cch);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1 chk("t6_drain_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
